vga_timing_gen: RTL and testbench

//  Parametrised two-axis raster timing generator. It supersedes the fixed
//  0..524 vertical counter with a paired horizontal and vertical counter.

---
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 tb/tb_vga_timing_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Two-axis raster timing generator: paired horizontal/vertical counters with
// per-axis phase FSMs and registered, mutually aligned sync/blank/pulse outputs.
module vga_timing_gen #(
  parameter int CNT_W     = 10,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_end,
  output logic             frame_end
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST        = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_FRONT_START = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_START  = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] H_BACK_START  = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic             H_FP_ZERO     = (H_FP == 0);
  localparam logic             H_BP_ZERO     = (H_BP == 0);

  localparam logic [CNT_W-1:0] V_LAST        = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_FRONT_START = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_SYNC_START  = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] V_BACK_START  = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic             V_FP_ZERO     = (V_FP == 0);
  localparam logic             V_BP_ZERO     = (V_BP == 0);

  localparam logic [1:0] ACTIVE = 2'd0;
  localparam logic [1:0] FRONT  = 2'd1;
  localparam logic [1:0] SYNC   = 2'd2;
  localparam logic [1:0] BACK   = 2'd3;

  logic [1:0]       hPhase, vPhase;
  logic [1:0]       hPhaseNext, vPhaseNext;
  logic [CNT_W-1:0] hNext, vNext;
  logic             hWrap, vWrap;

  // Phase is decided from the count the axis is about to hold, so the
  // registered sync level lines up with the registered count. A zero-width
  // porch jumps straight past its phase; a count of zero always means ACTIVE.
  function automatic logic [1:0] advancePhase(
    input logic [1:0]       phase,
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] frontStart,
    input logic [CNT_W-1:0] syncStart,
    input logic [CNT_W-1:0] backStart,
    input logic             fpZero,
    input logic             bpZero
  );
    advancePhase = phase;
    if (cnt == '0) begin
      advancePhase = ACTIVE;
    end else begin
      case (phase)
        ACTIVE:  if (cnt == frontStart) advancePhase = fpZero ? SYNC : FRONT;
        FRONT:   if (cnt == syncStart) advancePhase = SYNC;
        SYNC:    if (cnt == backStart && !bpZero) advancePhase = BACK;
        default: advancePhase = phase;
      endcase
    end
  endfunction

  always_comb begin
    hWrap = pix_en && (hcount == H_LAST);
    vWrap = hWrap && (vcount == V_LAST);
    hNext = hcount;
    vNext = vcount;
    if (pix_en) begin
      hNext = hWrap ? '0 : hcount + CNT_W'(1);
    end
    if (hWrap) begin
      vNext = vWrap ? '0 : vcount + CNT_W'(1);
    end
    hPhaseNext = hPhase;
    vPhaseNext = vPhase;
    if (pix_en) begin
      hPhaseNext = advancePhase(hPhase, hNext, H_FRONT_START, H_SYNC_START,
                                H_BACK_START, H_FP_ZERO, H_BP_ZERO);
    end
    if (hWrap) begin
      vPhaseNext = advancePhase(vPhase, vNext, V_FRONT_START, V_SYNC_START,
                                V_BACK_START, V_FP_ZERO, V_BP_ZERO);
    end
  end

  // Without a pixel tick everything holds except the pulses, which drop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hcount    <= '0;
      vcount    <= '0;
      hPhase    <= ACTIVE;
      vPhase    <= ACTIVE;
      hsync     <= ~HSYNC_POL;
      vsync     <= ~VSYNC_POL;
      video_on  <= 1'b1;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      line_end  <= hWrap;
      frame_end <= vWrap;
      if (pix_en) begin
        hcount   <= hNext;
        vcount   <= vNext;
        hPhase   <= hPhaseNext;
        vPhase   <= vPhaseNext;
        hsync    <= (hPhaseNext == SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync    <= (vPhaseNext == SYNC) ? VSYNC_POL : ~VSYNC_POL;
        video_on <= (hNext < H_FRONT_START) && (vNext < V_FRONT_START);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance for line timing
// and a tiny instance (zero front porch, active-high hsync) for frame timing.
module tb_vga_timing_gen;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rstA, pixA, rstB, pixB;
  logic [9:0] hA, vA;
  logic       hsA, vsA, voA, leA, feA;
  logic [4:0] hB, vB;
  logic       hsB, vsB, voB, leB, feB;

  int vectorCount = 0;
  int missCount   = 0;

  vga_timing_gen dutA (
    .Clk(Clk), .Reset(rstA), .pix_en(pixA),
    .hcount(hA), .vcount(vA), .hsync(hsA), .vsync(vsA),
    .video_on(voA), .line_end(leA), .frame_end(feA)
  );

  // Small raster: H = 8 visible, 0 front porch, 3 sync, 2 back (13 total);
  // V = 4 visible, 1 front, 2 sync, 1 back (8 total); hsync active-high.
  vga_timing_gen #(
    .CNT_W(5), .H_VISIBLE(8), .H_FP(0), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) dutB (
    .Clk(Clk), .Reset(rstB), .pix_en(pixB),
    .hcount(hB), .vcount(vB), .hsync(hsB), .vsync(vsB),
    .video_on(voB), .line_end(leB), .frame_end(feB)
  );

  typedef struct {
    int inst;
    int ticks;
    int h;
    int v;
    int hs;
    int vs;
    int vo;
    int le;
    int fe;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs[NVEC];
  int   tA = 0;
  int   tB = 0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkA(input string tag, input int h, input int v, input int hs,
                        input int vs, input int vo, input int le, input int fe);
    checkOutput({tag, " A hcount"}, int'(hA), h);
    checkOutput({tag, " A vcount"}, int'(vA), v);
    checkOutput({tag, " A hsync"}, int'(hsA), hs);
    checkOutput({tag, " A vsync"}, int'(vsA), vs);
    checkOutput({tag, " A video_on"}, int'(voA), vo);
    checkOutput({tag, " A line_end"}, int'(leA), le);
    checkOutput({tag, " A frame_end"}, int'(feA), fe);
  endtask

  task automatic checkB(input string tag, input int h, input int v, input int hs,
                        input int vs, input int vo, input int le, input int fe);
    checkOutput({tag, " B hcount"}, int'(hB), h);
    checkOutput({tag, " B vcount"}, int'(vB), v);
    checkOutput({tag, " B hsync"}, int'(hsB), hs);
    checkOutput({tag, " B vsync"}, int'(vsB), vs);
    checkOutput({tag, " B video_on"}, int'(voB), vo);
    checkOutput({tag, " B line_end"}, int'(leB), le);
    checkOutput({tag, " B frame_end"}, int'(feB), fe);
  endtask

  // Advances the selected instance with pix_en=1 until it has seen the
  // vector's cumulative tick count, then compares all outputs.
  task automatic applyStimulus(input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (vecs[idx].inst == 0) begin
      while (tA < vecs[idx].ticks) begin
        pixA = 1'b1;
        step();
        tA++;
      end
      pixA = 1'b0;
      checkA(tag, vecs[idx].h, vecs[idx].v, vecs[idx].hs, vecs[idx].vs,
             vecs[idx].vo, vecs[idx].le, vecs[idx].fe);
    end else begin
      while (tB < vecs[idx].ticks) begin
        pixB = 1'b1;
        step();
        tB++;
      end
      pixB = 1'b0;
      checkB(tag, vecs[idx].h, vecs[idx].v, vecs[idx].hs, vecs[idx].vs,
             vecs[idx].vo, vecs[idx].le, vecs[idx].fe);
    end
  endtask

  initial begin
    int clocks;

    //          inst ticks   h    v  hs vs vo le fe
    vecs[0]  = '{0,    0,    0,   0, 1, 1, 1, 0, 0};
    vecs[1]  = '{0,    1,    1,   0, 1, 1, 1, 0, 0};
    vecs[2]  = '{0,  639,  639,   0, 1, 1, 1, 0, 0};
    vecs[3]  = '{0,  640,  640,   0, 1, 1, 0, 0, 0};
    vecs[4]  = '{0,  655,  655,   0, 1, 1, 0, 0, 0};
    vecs[5]  = '{0,  656,  656,   0, 0, 1, 0, 0, 0};
    vecs[6]  = '{0,  751,  751,   0, 0, 1, 0, 0, 0};
    vecs[7]  = '{0,  752,  752,   0, 1, 1, 0, 0, 0};
    vecs[8]  = '{0,  799,  799,   0, 1, 1, 0, 0, 0};
    vecs[9]  = '{0,  800,    0,   1, 1, 1, 1, 1, 0};
    vecs[10] = '{0,  801,    1,   1, 1, 1, 1, 0, 0};
    vecs[11] = '{1,    0,    0,   0, 0, 1, 1, 0, 0};
    vecs[12] = '{1,    7,    7,   0, 0, 1, 1, 0, 0};
    vecs[13] = '{1,    8,    8,   0, 1, 1, 0, 0, 0};
    vecs[14] = '{1,   10,   10,   0, 1, 1, 0, 0, 0};
    vecs[15] = '{1,   11,   11,   0, 0, 1, 0, 0, 0};
    vecs[16] = '{1,   12,   12,   0, 0, 1, 0, 0, 0};
    vecs[17] = '{1,   13,    0,   1, 0, 1, 1, 1, 0};
    vecs[18] = '{1,   52,    0,   4, 0, 1, 0, 1, 0};
    vecs[19] = '{1,   65,    0,   5, 0, 0, 0, 1, 0};
    vecs[20] = '{1,   78,    0,   6, 0, 0, 0, 1, 0};
    vecs[21] = '{1,   91,    0,   7, 0, 1, 0, 1, 0};
    vecs[22] = '{1,  103,   12,   7, 0, 1, 0, 0, 0};
    vecs[23] = '{1,  104,    0,   0, 0, 1, 1, 1, 1};
    vecs[24] = '{1,  105,    1,   0, 0, 1, 1, 0, 0};

    rstA = 1'b1;
    rstB = 1'b1;
    pixA = 1'b1;
    pixB = 1'b1;
    repeat (3) step();
    rstA = 1'b0;
    rstB = 1'b0;
    pixA = 1'b0;
    pixB = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(i);
    end

    // Mid-line freeze on the default raster: hcount 100 of line 1.
    while (tA < 900) begin
      pixA = 1'b1;
      step();
      tA++;
    end
    pixA = 1'b0;
    repeat (20) step();
    checkA("freeze", 100, 1, 1, 1, 1, 0, 0);

    // Line-end pulse must drop on a non-tick clock even though hcount holds.
    while (tA < 1600) begin
      pixA = 1'b1;
      step();
      tA++;
    end
    pixA = 1'b0;
    checkA("wrap1600", 0, 2, 1, 1, 1, 1, 0);
    step();
    checkA("pulseDrop", 0, 2, 1, 1, 1, 0, 0);

    // Half-rate pixel tick: one line spans 1600 clocks, pulse still 1 clock.
    clocks = 0;
    for (int c = 1; c <= 4000; c++) begin
      pixA = (c % 2 == 0);
      step();
      if (leA === 1'b1) begin
        clocks = c;
        break;
      end
    end
    checkOutput("halfRate line clocks", clocks, 1600);
    pixA = 1'b0;
    step();
    checkA("halfRate after", 0, 3, 1, 1, 1, 0, 0);

    // Reset mid-frame on the small raster at line 5, column 9 (inside both syncs).
    while (tB < 178) begin
      pixB = 1'b1;
      step();
      tB++;
    end
    pixB = 1'b0;
    checkB("preReset", 9, 5, 1, 0, 0, 0, 0);
    rstB = 1'b1;
    pixB = 1'b1;
    step();
    rstB = 1'b0;
    pixB = 1'b0;
    checkB("midReset", 0, 0, 0, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
